// File: rtl/mips_pkg.sv
// Shared types and constants for the MIPS memory-access pipeline stage.
package mips_pkg;

  localparam int DATA_W = 32;
  localparam int REG_W  = 5;

  // IDLE accepts a new execute bundle; WAIT holds one outstanding bus access.
  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } mem_state_t;

  localparam logic [1:0] ERR_NONE     = 2'b00;
  localparam logic [1:0] ERR_MISALIGN = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT  = 2'b10;
  localparam logic [1:0] ERR_CTRL     = 2'b11;

  // Word accesses only: the two low byte-address bits must be zero.
  function automatic logic is_word_aligned(input logic [DATA_W-1:0] addr);
    return (addr[1:0] == 2'b00);
  endfunction

endpackage

// File: rtl/dmem_watchdog.sv
// Counts cycles spent waiting on the data-memory acknowledge and flags the
// last permitted cycle so the stage can abort on the following edge.
module dmem_watchdog #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] count_q, count_d;

  // Expired during the final waiting cycle: count equals cycles already waited.
  always_comb begin
    expired = enable && (count_q == LIMIT);
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable && !expired) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  // Cycle counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/memory_access_stage.sv
// MEM stage: word loads/stores over a req/ack bus with a watchdog, branch
// resolution, and a registered single-cycle writeback bundle.
//
// Handshake: a bundle transfers on a rising edge where EX_VALID and EX_READY
// are both high; EX_READY depends only on state, and the bus holds
// DMEM_REQ/ADDR/WDATA/WE stable until the edge that samples DMEM_ACK high.
module memory_access_stage
  import mips_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              EX_VALID,
  output logic              EX_READY,
  input  logic [DATA_W-1:0] ALU_RESULT,
  input  logic              ZERO,
  input  logic [DATA_W-1:0] WRITE_DATA,
  input  logic [REG_W-1:0]  WRITE_REGISTER,
  input  logic [DATA_W-1:0] BRANCH_TARGET,
  input  logic              MEM_READ,
  input  logic              MEM_WRITE,
  input  logic              BRANCH,
  input  logic              REG_WRITE,
  input  logic              MEM_TO_REG,
  output logic              PC_SRC,
  output logic [DATA_W-1:0] PC_TARGET,
  output logic              DMEM_REQ,
  output logic              DMEM_WE,
  output logic [DATA_W-1:0] DMEM_ADDR,
  output logic [DATA_W-1:0] DMEM_WDATA,
  input  logic [DATA_W-1:0] DMEM_RDATA,
  input  logic              DMEM_ACK,
  output logic              WB_VALID,
  output logic              WB_REG_WRITE,
  output logic [REG_W-1:0]  WB_REGISTER,
  output logic [DATA_W-1:0] WB_DATA,
  output logic              ERR,
  output logic [1:0]        ERR_CODE,
  output mem_state_t        dbg_state
);

  mem_state_t        state_q, state_d;
  logic              pc_src_q, pc_src_d;
  logic [DATA_W-1:0] pc_target_q, pc_target_d;
  logic              req_q, req_d;
  logic              we_q, we_d;
  logic [DATA_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              wb_valid_q, wb_valid_d;
  logic              wb_reg_write_q, wb_reg_write_d;
  logic [REG_W-1:0]  wb_register_q, wb_register_d;
  logic [DATA_W-1:0] wb_data_q, wb_data_d;
  logic              err_q, err_d;
  logic [1:0]        err_code_q, err_code_d;
  // Bundle fields needed when an outstanding access completes.
  logic              reg_write_q, reg_write_d;
  logic              mem_to_reg_q, mem_to_reg_d;
  logic [DATA_W-1:0] alu_q, alu_d;

  logic accept;
  logic is_mem;
  logic wd_clear;
  logic wd_expired;

  dmem_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk    (CLK),
    .rst    (RESET),
    .clear  (wd_clear),
    .enable (state_q == WAIT),
    .expired(wd_expired)
  );

  assign EX_READY     = (state_q == IDLE);
  assign accept       = EX_VALID && EX_READY;
  assign is_mem       = MEM_READ || MEM_WRITE;
  assign dbg_state    = state_q;
  assign PC_SRC       = pc_src_q;
  assign PC_TARGET    = pc_target_q;
  assign DMEM_REQ     = req_q;
  assign DMEM_WE      = we_q;
  assign DMEM_ADDR    = addr_q;
  assign DMEM_WDATA   = wdata_q;
  assign WB_VALID     = wb_valid_q;
  assign WB_REG_WRITE = wb_reg_write_q;
  assign WB_REGISTER  = wb_register_q;
  assign WB_DATA      = wb_data_q;
  assign ERR          = err_q;
  assign ERR_CODE     = err_code_q;

  // Next-state and registered-output logic; pulses default low every cycle.
  always_comb begin
    state_d        = state_q;
    pc_src_d       = 1'b0;
    pc_target_d    = pc_target_q;
    req_d          = req_q;
    we_d           = we_q;
    addr_d         = addr_q;
    wdata_d        = wdata_q;
    wb_valid_d     = 1'b0;
    wb_reg_write_d = wb_reg_write_q;
    wb_register_d  = wb_register_q;
    wb_data_d      = wb_data_q;
    err_d          = 1'b0;
    err_code_d     = ERR_NONE;
    reg_write_d    = reg_write_q;
    mem_to_reg_d   = mem_to_reg_q;
    alu_d          = alu_q;
    wd_clear       = 1'b0;

    case (state_q)
      IDLE: begin
        if (accept) begin
          wb_register_d = WRITE_REGISTER;
          reg_write_d   = REG_WRITE;
          mem_to_reg_d  = MEM_TO_REG;
          alu_d         = ALU_RESULT;
          if (BRANCH && ZERO) begin
            pc_src_d    = 1'b1;
            pc_target_d = BRANCH_TARGET;
          end
          if (MEM_READ && MEM_WRITE) begin
            // Contradictory controls: report and retire without touching the bus.
            err_d          = 1'b1;
            err_code_d     = ERR_CTRL;
            wb_valid_d     = 1'b1;
            wb_reg_write_d = 1'b0;
            wb_data_d      = ALU_RESULT;
          end else if (is_mem && !is_word_aligned(ALU_RESULT)) begin
            err_d          = 1'b1;
            err_code_d     = ERR_MISALIGN;
            wb_valid_d     = 1'b1;
            wb_reg_write_d = 1'b0;
            wb_data_d      = ALU_RESULT;
          end else if (is_mem) begin
            state_d  = WAIT;
            req_d    = 1'b1;
            we_d     = MEM_WRITE;
            addr_d   = ALU_RESULT;
            wdata_d  = WRITE_DATA;
            wd_clear = 1'b1;
          end else begin
            wb_valid_d     = 1'b1;
            wb_reg_write_d = REG_WRITE;
            wb_data_d      = ALU_RESULT;
          end
        end
      end
      WAIT: begin
        if (DMEM_ACK) begin
          // Acknowledge wins over a watchdog expiring in the same cycle.
          state_d        = IDLE;
          req_d          = 1'b0;
          we_d           = 1'b0;
          wb_valid_d     = 1'b1;
          wb_reg_write_d = we_q ? 1'b0 : reg_write_q;
          wb_data_d      = mem_to_reg_q ? DMEM_RDATA : alu_q;
        end else if (wd_expired) begin
          state_d        = IDLE;
          req_d          = 1'b0;
          we_d           = 1'b0;
          err_d          = 1'b1;
          err_code_d     = ERR_TIMEOUT;
          wb_valid_d     = 1'b1;
          wb_reg_write_d = 1'b0;
          wb_data_d      = alu_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers; reset discards any pending access.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q        <= IDLE;
      pc_src_q       <= 1'b0;
      pc_target_q    <= '0;
      req_q          <= 1'b0;
      we_q           <= 1'b0;
      addr_q         <= '0;
      wdata_q        <= '0;
      wb_valid_q     <= 1'b0;
      wb_reg_write_q <= 1'b0;
      wb_register_q  <= '0;
      wb_data_q      <= '0;
      err_q          <= 1'b0;
      err_code_q     <= ERR_NONE;
      reg_write_q    <= 1'b0;
      mem_to_reg_q   <= 1'b0;
      alu_q          <= '0;
    end else begin
      state_q        <= state_d;
      pc_src_q       <= pc_src_d;
      pc_target_q    <= pc_target_d;
      req_q          <= req_d;
      we_q           <= we_d;
      addr_q         <= addr_d;
      wdata_q        <= wdata_d;
      wb_valid_q     <= wb_valid_d;
      wb_reg_write_q <= wb_reg_write_d;
      wb_register_q  <= wb_register_d;
      wb_data_q      <= wb_data_d;
      err_q          <= err_d;
      err_code_q     <= err_code_d;
      reg_write_q    <= reg_write_d;
      mem_to_reg_q   <= mem_to_reg_d;
      alu_q          <= alu_d;
    end
  end

endmodule

// File: tb/tb_memory_access_stage.sv
// Directed bench for memory_access_stage: stimulus pushes expected writeback
// bundles, a negedge monitor pops and compares them whenever WB_VALID is high.
module tb_memory_access_stage;
  import mips_pkg::*;

  localparam int TO = 4;
  // Entry: {chk_data, reg_write, register[5], data[32], err, code[2], pc_src}
  localparam int EW = 43;

  logic              clk = 1'b0;
  logic              rst;
  logic              ex_valid;
  logic              ex_ready;
  logic [31:0]       alu_result;
  logic              zero;
  logic [31:0]       write_data;
  logic [4:0]        write_register;
  logic [31:0]       branch_target;
  logic              mem_read, mem_write, branch, reg_write, mem_to_reg;
  logic              pc_src;
  logic [31:0]       pc_target;
  logic              dmem_req, dmem_we;
  logic [31:0]       dmem_addr, dmem_wdata, dmem_rdata;
  logic              dmem_ack;
  logic              wb_valid, wb_reg_write;
  logic [4:0]        wb_register;
  logic [31:0]       wb_data;
  logic              err;
  logic [1:0]        err_code;
  mem_state_t        dbg_state;

  logic [EW-1:0] exp_q[$];
  logic [31:0]   exp_pc_target;
  int n_checks = 0;
  int n_fail   = 0;

  memory_access_stage #(.TIMEOUT_CYCLES(TO)) dut (
    .CLK(clk), .RESET(rst), .EX_VALID(ex_valid), .EX_READY(ex_ready),
    .ALU_RESULT(alu_result), .ZERO(zero), .WRITE_DATA(write_data),
    .WRITE_REGISTER(write_register), .BRANCH_TARGET(branch_target),
    .MEM_READ(mem_read), .MEM_WRITE(mem_write), .BRANCH(branch),
    .REG_WRITE(reg_write), .MEM_TO_REG(mem_to_reg), .PC_SRC(pc_src),
    .PC_TARGET(pc_target), .DMEM_REQ(dmem_req), .DMEM_WE(dmem_we),
    .DMEM_ADDR(dmem_addr), .DMEM_WDATA(dmem_wdata), .DMEM_RDATA(dmem_rdata),
    .DMEM_ACK(dmem_ack), .WB_VALID(wb_valid), .WB_REG_WRITE(wb_reg_write),
    .WB_REGISTER(wb_register), .WB_DATA(wb_data), .ERR(err),
    .ERR_CODE(err_code), .dbg_state(dbg_state)
  );

  // Clock and run-time bound.
  always #5 clk = ~clk;
  initial begin
    #200000;
    $display("FAIL sim_timeout: bench did not finish within time limit");
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [EW-1:0] mk(input logic chk, input logic rw, input logic [4:0] rg,
                                      input logic [31:0] d, input logic e, input logic [1:0] c,
                                      input logic pc);
    return {chk, rw, rg, d, e, c, pc};
  endfunction

  task automatic drive(input logic [31:0] alu, input logic [31:0] wd, input logic [31:0] bt,
                       input logic [4:0] wr, input logic z, input logic mr, input logic mw,
                       input logic br, input logic rw, input logic m2r);
    ex_valid       = 1'b1;
    alu_result     = alu;
    write_data     = wd;
    branch_target  = bt;
    write_register = wr;
    zero           = z;
    mem_read       = mr;
    mem_write      = mw;
    branch         = br;
    reg_write      = rw;
    mem_to_reg     = m2r;
  endtask

  // Scoreboard monitor: compare every writeback bundle against the queue head.
  always @(negedge clk) begin
    logic [EW-1:0] e;
    logic [EW-1:0] a;
    if (!rst && wb_valid) begin
      if (exp_q.size() == 0) begin
        check("wb_unexpected", {63'd0, wb_valid}, 64'd0);
      end else begin
        e = exp_q.pop_front();
        a = {e[42], wb_reg_write, wb_register, (e[42] ? wb_data : e[35:4]),
             err, err_code, pc_src};
        check("wb_bundle", 64'(a), 64'(e));
        if (e[0]) check("pc_target", 64'(pc_target), 64'(exp_pc_target));
      end
    end
  end

  initial begin
    int low_cnt;
    int req_cnt;
    rst = 1'b1; ex_valid = 1'b0; alu_result = '0; zero = 1'b0; write_data = '0;
    write_register = '0; branch_target = '0; mem_read = 1'b0; mem_write = 1'b0;
    branch = 1'b0; reg_write = 1'b0; mem_to_reg = 1'b0; dmem_rdata = '0; dmem_ack = 1'b0;
    exp_pc_target = '0;

    // Reset values.
    repeat (2) @(negedge clk);
    check("rst_ex_ready", 64'(ex_ready), 64'd1);
    check("rst_outputs", 64'({dmem_req, wb_valid, err, pc_src, err_code}), 64'd0);
    rst = 1'b0;

    // Non-memory bundle, single-cycle latency.
    @(negedge clk);
    drive(32'd31, 32'd0, 32'd0, 5'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    exp_q.push_back(mk(1'b1, 1'b1, 5'd2, 32'd31, 1'b0, 2'b00, 1'b0));
    @(negedge clk);
    ex_valid = 1'b0;
    check("nm_latency", 64'(wb_valid), 64'd1);

    // Back-to-back non-memory bundles.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (i > 0) check("b2b_wb_valid", 64'(wb_valid), 64'd1);
      check("b2b_ex_ready", 64'(ex_ready), 64'd1);
      drive(32'h1000 + 32'(i), 32'd0, 32'd0, 5'(10 + i), 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      exp_q.push_back(mk(1'b1, 1'b1, 5'(10 + i), 32'h1000 + 32'(i), 1'b0, 2'b00, 1'b0));
    end
    @(negedge clk);
    ex_valid = 1'b0;
    check("b2b_last_wb", 64'(wb_valid), 64'd1);

    // Branch taken, then not taken.
    @(negedge clk);
    drive(32'd0, 32'd0, 32'h8C, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    exp_pc_target = 32'h8C;
    exp_q.push_back(mk(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 2'b00, 1'b1));
    @(negedge clk);
    drive(32'd4, 32'd0, 32'h200, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    exp_q.push_back(mk(1'b1, 1'b0, 5'd0, 32'd4, 1'b0, 2'b00, 1'b0));
    @(negedge clk);
    ex_valid = 1'b0;
    @(negedge clk);
    check("pc_target_held", 64'(pc_target), 64'h8C);

    // Load at 0x100, acknowledged in the fourth waiting cycle.
    @(negedge clk);
    drive(32'h100, 32'd0, 32'd0, 5'd5, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    exp_q.push_back(mk(1'b1, 1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 2'b00, 1'b0));
    low_cnt = 0;
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      ex_valid = 1'b0;
      if (!ex_ready) low_cnt++;
      if (i == 1) check("ld_bus", 64'({dmem_req, dmem_we, dmem_addr}), {30'd0, 2'b10, 32'h100});
      if (i == 4) begin
        check("ld_addr_stable", 64'(dmem_addr), 64'h100);
        dmem_ack = 1'b1;
        dmem_rdata = 32'hDEADBEEF;
      end
    end
    @(negedge clk);
    dmem_ack = 1'b0;
    dmem_rdata = 32'h0;
    if (!ex_ready) low_cnt++;
    check("ld_ready_low_cycles", 64'(low_cnt), 64'd4);
    check("ld_req_drop", 64'(dmem_req), 64'd0);

    // Store at 0x104, acknowledged in the same cycle REQ rises.
    @(negedge clk);
    drive(32'h104, 32'd17, 32'd0, 5'd7, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    exp_q.push_back(mk(1'b1, 1'b0, 5'd7, 32'h104, 1'b0, 2'b00, 1'b0));
    @(negedge clk);
    ex_valid = 1'b0;
    check("st_bus", 64'({dmem_req, dmem_we, dmem_wdata}), {30'd0, 2'b11, 32'd17});
    check("st_addr", 64'(dmem_addr), 64'h104);
    dmem_ack = 1'b1;
    dmem_rdata = 32'hA5A5A5A5;
    @(negedge clk);
    dmem_ack = 1'b0;
    check("st_req_drop", 64'(dmem_req), 64'd0);

    // Stray acknowledge while idle must be ignored.
    @(negedge clk);
    dmem_ack = 1'b1;
    @(negedge clk);
    dmem_ack = 1'b0;
    check("stray_ack", 64'({dmem_req, ex_ready}), 64'b01);

    // Misaligned load, then read+write both set.
    @(negedge clk);
    drive(32'h102, 32'd0, 32'd0, 5'd9, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    exp_q.push_back(mk(1'b0, 1'b0, 5'd9, 32'd0, 1'b1, 2'b01, 1'b0));
    @(negedge clk);
    drive(32'h200, 32'd3, 32'd0, 5'd4, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    exp_q.push_back(mk(1'b0, 1'b0, 5'd4, 32'd0, 1'b1, 2'b11, 1'b0));
    check("mis_no_req", 64'({dmem_req, ex_ready}), 64'b01);
    @(negedge clk);
    ex_valid = 1'b0;
    check("ctrl_no_req", 64'({dmem_req, ex_ready}), 64'b01);

    // Load with no acknowledge: watchdog abort.
    @(negedge clk);
    drive(32'h300, 32'd0, 32'd0, 5'd6, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    exp_q.push_back(mk(1'b0, 1'b0, 5'd6, 32'd0, 1'b1, 2'b10, 1'b0));
    req_cnt = 0;
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk);
      ex_valid = 1'b0;
      if (dmem_req) req_cnt++;
      if (i == 5) check("to_err_timing", 64'({err, dmem_req, ex_ready}), 64'b101);
    end
    check("to_req_cycles", 64'(req_cnt), 64'(TO));

    // Reset in the middle of a wait.
    @(negedge clk);
    drive(32'h400, 32'd0, 32'd0, 5'd8, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    @(negedge clk);
    ex_valid = 1'b0;
    check("mid_wait_req", 64'({dmem_req, ex_ready}), 64'b10);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("rst_mid_wait", 64'({dmem_req, ex_ready, dbg_state}), 64'b010);
    @(negedge clk);
    rst = 1'b0;
    repeat (TO + 3) @(negedge clk);
    check("post_rst_idle", 64'({dmem_req, ex_ready, err}), 64'b010);

    check("sb_drain", 64'(exp_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule
